// File: rtl/multicycle_uc_param_if.sv
// Control-unit <-> datapath bundle: IR opcode, ALU zero flag and memory ready
// flow into the control unit; mux selects, ALU op, write enables, the retire
// pulse, the trap flag and the retired-instruction count flow back out.
// master = control unit, slave = datapath side.
interface multicycle_uc_param_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic [3:0]       state_reg;
  logic [1:0]       aluop;
  logic             Mux1;
  logic [1:0]       Mux2;
  logic             Mux3;
  logic             Mux4;
  logic             Mux5;
  logic             weMem;
  logic             weReg;
  logic             weIR;
  logic             wePc;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, zero, mem_ready,
    output state_reg, aluop, Mux1, Mux2, Mux3, Mux4, Mux5,
           weMem, weReg, weIR, wePc, instr_done, illegal, instret
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  state_reg, aluop, Mux1, Mux2, Mux3, Mux4, Mux5,
           weMem, weReg, weIR, wePc, instr_done, illegal, instret
  );
endinterface

// File: rtl/multicycle_uc_param.sv
// Purpose: multicycle RV32-subset control unit (R/I ALU ops, LW, SW, BEQ, illegal-opcode trap).
// Latency: R/I 4 cycles, LW 5, SW 4, BEQ 3; each memory state adds MEM_WAIT cycles.
// Backpressure: memory states hold until the wait count expires and, if enabled, mem_ready=1.
// Ports: clk, reset (sync, active-high); bus (master): opcode/zero/mem_ready in,
//        state_reg, aluop, Mux1..Mux5, weMem/weReg/weIR/wePc, instr_done, illegal, instret out.
module multicycle_uc_param #(
  parameter int MEM_WAIT      = 0,
  parameter int USE_MEM_READY = 0,
  parameter int CNT_W         = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_uc_param_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    MEM_ADDR  = 4'd4,
    MEM_READ  = 4'd5,
    MEM_WRITE = 4'd6,
    MEM_WB    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] WAIT_LIM = 4'(MEM_WAIT);
  localparam bit         READY_EN = (USE_MEM_READY != 0);

  state_t           state;
  logic [3:0]       wcnt;
  logic             illegalQ;
  logic [CNT_W-1:0] instretQ;

  logic             isMem;
  logic             go;

  logic [1:0]       aluopC;
  logic             mux1C;
  logic [1:0]       mux2C;
  logic             mux3C;
  logic             mux4C;
  logic             mux5C;
  logic             weMemC;
  logic             weRegC;
  logic             weIRC;
  logic             wePcC;
  logic             doneC;

  assign isMem = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);

  // A memory state may only advance once its wait count has saturated; the
  // ready handshake is only looked at after that, so an early ready is ignored.
  assign go = (wcnt == WAIT_LIM) && (!READY_EN || bus.mem_ready);

  // Output decode: Moore in state, with memory-state enables gated by go and
  // the branch PC write gated by the ALU zero flag. Reset forces everything low.
  always_comb begin
    aluopC = 2'b00;
    mux1C  = 1'b0;
    mux2C  = 2'b00;
    mux3C  = 1'b0;
    mux4C  = 1'b0;
    mux5C  = 1'b0;
    weMemC = 1'b0;
    weRegC = 1'b0;
    weIRC  = 1'b0;
    wePcC  = 1'b0;
    doneC  = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mux2C = 2'b01;
          weIRC = go;
          wePcC = go;
        end
        DECODE: begin
          // ALUOut <= PC + imm, kept as the branch target
          mux2C = 2'b10;
        end
        EXEC_R: begin
          mux3C  = 1'b1;
          aluopC = 2'b10;
        end
        EXEC_I: begin
          mux3C  = 1'b1;
          mux2C  = 2'b10;
          aluopC = 2'b10;
        end
        MEM_ADDR: begin
          mux3C = 1'b1;
          mux2C = 2'b10;
        end
        MEM_READ: begin
          mux1C = 1'b1;
        end
        MEM_WRITE: begin
          mux1C  = 1'b1;
          weMemC = go;
          doneC  = go;
        end
        MEM_WB: begin
          mux4C  = 1'b1;
          weRegC = 1'b1;
          doneC  = 1'b1;
        end
        ALU_WB: begin
          weRegC = 1'b1;
          doneC  = 1'b1;
        end
        BRANCH: begin
          mux3C  = 1'b1;
          aluopC = 2'b01;
          mux5C  = 1'b1;
          wePcC  = bus.zero;
          doneC  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wcnt     <= 4'd0;
      instretQ <= '0;
      illegalQ <= 1'b0;
    end else begin
      if (doneC) begin
        instretQ <= instretQ + CNT_W'(1);
      end

      // Wait counter saturates at the limit while stalled on ready, and is
      // cleared on the cycle the memory state is left.
      if (isMem && !go) begin
        if (wcnt != WAIT_LIM) begin
          wcnt <= wcnt + 4'd1;
        end
      end else begin
        wcnt <= 4'd0;
      end

      case (state)
        FETCH: begin
          if (go) state <= DECODE;
        end
        DECODE: begin
          case (bus.opcode)
            OP_R:          state <= EXEC_R;
            OP_I:          state <= EXEC_I;
            OP_LW, OP_SW:  state <= MEM_ADDR;
            OP_BEQ:        state <= BRANCH;
            default: begin
              state    <= TRAP;
              illegalQ <= 1'b1;
            end
          endcase
        end
        EXEC_R, EXEC_I: state <= ALU_WB;
        MEM_ADDR:       state <= (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ: begin
          if (go) state <= MEM_WB;
        end
        MEM_WRITE: begin
          if (go) state <= FETCH;
        end
        MEM_WB, ALU_WB, BRANCH: state <= FETCH;
        TRAP: begin
          state    <= TRAP;
          illegalQ <= 1'b1;
        end
        // unused encodings are treated as a trap
        default: begin
          state    <= TRAP;
          illegalQ <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state_reg  = state;
  assign bus.aluop      = aluopC;
  assign bus.Mux1       = mux1C;
  assign bus.Mux2       = mux2C;
  assign bus.Mux3       = mux3C;
  assign bus.Mux4       = mux4C;
  assign bus.Mux5       = mux5C;
  assign bus.weMem      = weMemC;
  assign bus.weReg      = weRegC;
  assign bus.weIR       = weIRC;
  assign bus.wePc       = wePcC;
  assign bus.instr_done = doneC;
  assign bus.illegal    = illegalQ;
  assign bus.instret    = instretQ;

endmodule

// File: tb/tb_multicycle_uc_param.sv
// Bench for multicycle_uc_param: two instances share the same stimulus
// (A = default parameters, B = MEM_WAIT=2, USE_MEM_READY=1, CNT_W=4); sel picks
// which one is observed. Each cycle's stimulus and expected outputs are queued
// as one entry and consumed one clock at a time.
module tb_multicycle_uc_param;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_R = 4'd2, S_I = 4'd3, S_MA = 4'd4,
                         S_MR = 4'd5, S_MW = 4'd6, S_MWB = 4'd7, S_AWB = 4'd8,
                         S_BR = 4'd9, S_TRAP = 4'd15;

  // enables: {weMem, weReg, weIR, wePc, instr_done}
  localparam logic [4:0] EN_NONE = 5'b00000, EN_MEM = 5'b10000, EN_REG = 5'b01000,
                         EN_IR = 5'b00100, EN_PC = 5'b00010, EN_DONE = 5'b00001;

  // muxes: {aluop[1:0], Mux1, Mux2[1:0], Mux3, Mux4, Mux5}
  localparam logic [7:0] F_V   = 8'b00_0_01_0_0_0, F_M   = 8'b11_1_11_1_0_1;
  localparam logic [7:0] D_V   = 8'b00_0_10_0_0_0, D_M   = 8'b11_0_11_1_0_0;
  localparam logic [7:0] R_V   = 8'b10_0_00_1_0_0, I_V   = 8'b10_0_10_1_0_0;
  localparam logic [7:0] MA_V  = 8'b00_0_10_1_0_0, X_M   = 8'b11_0_11_1_0_0;
  localparam logic [7:0] AWB_V = 8'b00_0_00_0_0_0, AWB_M = 8'b00_0_00_0_1_0;
  localparam logic [7:0] MR_V  = 8'b00_1_00_0_0_0, MR_M  = 8'b00_1_00_0_0_0;
  localparam logic [7:0] MWB_V = 8'b00_0_00_0_1_0, MWB_M = 8'b00_0_00_0_1_0;
  localparam logic [7:0] BR_V  = 8'b01_0_00_1_0_1, BR_M  = 8'b11_0_11_1_0_1;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [6:0]  opc;
    logic        z;
    logic [3:0]  st;
    logic        stChk;
    logic [4:0]  en;
    logic [7:0]  mux;
    logic [7:0]  mask;
    logic [31:0] ir;
    logic        irChk;
    logic        ill;
    logic        illChk;
  } ent_t;

  logic clk;
  logic reset;
  logic sel;

  multicycle_uc_param_if #(.CNT_W(32)) ifA ();
  multicycle_uc_param_if #(.CNT_W(4))  ifB ();

  multicycle_uc_param #(.MEM_WAIT(0), .USE_MEM_READY(0), .CNT_W(32)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA.master)
  );

  multicycle_uc_param #(.MEM_WAIT(2), .USE_MEM_READY(1), .CNT_W(4)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  oSt;
  logic [4:0]  oEn;
  logic [7:0]  oMux;
  logic [31:0] oIr;
  logic        oIll;

  always_comb begin
    if (sel) begin
      oSt  = ifB.state_reg;
      oEn  = {ifB.weMem, ifB.weReg, ifB.weIR, ifB.wePc, ifB.instr_done};
      oMux = {ifB.aluop, ifB.Mux1, ifB.Mux2, ifB.Mux3, ifB.Mux4, ifB.Mux5};
      oIr  = 32'(ifB.instret);
      oIll = ifB.illegal;
    end else begin
      oSt  = ifA.state_reg;
      oEn  = {ifA.weMem, ifA.weReg, ifA.weIR, ifA.wePc, ifA.instr_done};
      oMux = {ifA.aluop, ifA.Mux1, ifA.Mux2, ifA.Mux3, ifA.Mux4, ifA.Mux5};
      oIr  = ifA.instret;
      oIll = ifA.illegal;
    end
  end

  ent_t        q[$];
  int          nChk = 0;
  int          nErr = 0;
  int          cyc  = 0;
  int          cfgWait = 0;
  logic        pRdy = 1'b0;
  logic [31:0] pIr = 32'd0;
  logic        pIrChk = 1'b0;
  logic        pIll = 1'b0;
  logic        pIllChk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // pending instret/illegal expectations attach to the next queued cycle
  task automatic expIr(input logic [31:0] v);
    pIr = v; pIrChk = 1'b1;
  endtask

  task automatic expIll(input logic v);
    pIll = v; pIllChk = 1'b1;
  endtask

  task automatic pushE(input logic rst, input logic stChk, input logic [6:0] opc, input logic z,
                       input logic [3:0] st, input logic [4:0] en, input logic [7:0] mux,
                       input logic [7:0] mask);
    ent_t e;
    e = '0;
    e.rst = rst; e.rdy = pRdy; e.opc = opc; e.z = z;
    e.st = st; e.stChk = stChk; e.en = en; e.mux = mux; e.mask = mask;
    e.ir = pIr; e.irChk = pIrChk; e.ill = pIll; e.illChk = pIllChk;
    pIrChk = 1'b0;
    pIllChk = 1'b0;
    q.push_back(e);
  endtask

  task automatic pushS(input logic [6:0] opc, input logic z, input logic [3:0] st,
                       input logic [4:0] en, input logic [7:0] mux, input logic [7:0] mask);
    pushE(1'b0, 1'b1, opc, z, st, en, mux, mask);
  endtask

  // reset cycle: every enable, mux and aluop must read 0
  task automatic pushRst(input logic [3:0] st, input logic stChk);
    pushE(1'b1, stChk, OP_R, 1'b0, st, EN_NONE, 8'h00, 8'hFF);
  endtask

  task automatic pFetch(input logic [6:0] opc, input logic z);
    for (int i = 0; i < cfgWait; i++) pushS(opc, z, S_F, EN_NONE, F_V, F_M);
    pushS(opc, z, S_F, EN_IR | EN_PC, F_V, F_M);
  endtask

  task automatic instR(input logic [6:0] opc);
    pFetch(opc, 1'b0);
    pushS(opc, 1'b0, S_D, EN_NONE, D_V, D_M);
    if (opc == OP_R) pushS(opc, 1'b0, S_R, EN_NONE, R_V, X_M);
    else             pushS(opc, 1'b0, S_I, EN_NONE, I_V, X_M);
    pushS(opc, 1'b0, S_AWB, EN_REG | EN_DONE, AWB_V, AWB_M);
  endtask

  task automatic instLw();
    pFetch(OP_LW, 1'b0);
    pushS(OP_LW, 1'b0, S_D, EN_NONE, D_V, D_M);
    pushS(OP_LW, 1'b0, S_MA, EN_NONE, MA_V, X_M);
    for (int i = 0; i <= cfgWait; i++) pushS(OP_LW, 1'b0, S_MR, EN_NONE, MR_V, MR_M);
    pushS(OP_LW, 1'b0, S_MWB, EN_REG | EN_DONE, MWB_V, MWB_M);
  endtask

  task automatic instSw(input int stallN);
    logic saveRdy;
    pFetch(OP_SW, 1'b0);
    pushS(OP_SW, 1'b0, S_D, EN_NONE, D_V, D_M);
    pushS(OP_SW, 1'b0, S_MA, EN_NONE, MA_V, X_M);
    for (int i = 0; i < cfgWait; i++) pushS(OP_SW, 1'b0, S_MW, EN_NONE, MR_V, MR_M);
    saveRdy = pRdy;
    pRdy = 1'b0;
    for (int i = 0; i < stallN; i++) pushS(OP_SW, 1'b0, S_MW, EN_NONE, MR_V, MR_M);
    pRdy = saveRdy | (stallN > 0);
    pushS(OP_SW, 1'b0, S_MW, EN_MEM | EN_DONE, MR_V, MR_M);
    pRdy = saveRdy;
  endtask

  task automatic instBeq(input logic z);
    pFetch(OP_BEQ, z);
    pushS(OP_BEQ, z, S_D, EN_NONE, D_V, D_M);
    pushS(OP_BEQ, z, S_BR, (z ? EN_PC : EN_NONE) | EN_DONE, BR_V, BR_M);
  endtask

  task automatic drain();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      cyc++;
      reset = e.rst;
      ifA.opcode = e.opc;    ifB.opcode = e.opc;
      ifA.zero = e.z;        ifB.zero = e.z;
      ifA.mem_ready = e.rdy; ifB.mem_ready = e.rdy;
      #1;
      if (e.stChk) chk($sformatf("state c%0d", cyc), 32'(oSt), 32'(e.st));
      chk($sformatf("enables c%0d", cyc), 32'(oEn), 32'(e.en));
      chk($sformatf("muxes c%0d", cyc), 32'(oMux & e.mask), 32'(e.mux & e.mask));
      if (e.irChk) chk($sformatf("instret c%0d", cyc), oIr, e.ir);
      if (e.illChk) chk($sformatf("illegal c%0d", cyc), 32'(oIll), 32'(e.ill));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", nChk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sel = 1'b0;
    ifA.opcode = OP_R; ifB.opcode = OP_R;
    ifA.zero = 1'b0;   ifB.zero = 1'b0;
    ifA.mem_ready = 1'b0; ifB.mem_ready = 1'b0;

    // Instance A: no wait states, mem_ready held low (must be ignored)
    sel = 1'b0; cfgWait = 0; pRdy = 1'b0;
    pushRst(S_F, 1'b0);
    expIr(32'd0); expIll(1'b0);
    instR(OP_R);
    expIr(32'd1); instR(OP_I);
    expIr(32'd2); instLw();
    expIr(32'd3); instSw(0);
    expIr(32'd4); instBeq(1'b1);
    expIr(32'd5); instBeq(1'b0);
    expIr(32'd6); expIll(1'b0);
    pFetch(OP_BAD, 1'b0);
    pushS(OP_BAD, 1'b0, S_D, EN_NONE, D_V, D_M);
    for (int i = 0; i < 10; i++) begin
      expIll(1'b1);
      if (i == 9) expIr(32'd6);
      pushS(OP_BAD, 1'b0, S_TRAP, EN_NONE, 8'h00, 8'h00);
    end
    pushRst(S_TRAP, 1'b1);
    expIll(1'b0); expIr(32'd0);
    instR(OP_R);
    drain();

    // Instance B: two wait states per memory state plus ready handshake
    sel = 1'b1; cfgWait = 2; pRdy = 1'b1;
    pushRst(S_F, 1'b0);
    expIr(32'd0);
    instLw();
    expIr(32'd1);
    instSw(4);
    expIr(32'd2);
    pushRst(S_F, 1'b1);
    for (int k = 0; k < 17; k++) begin
      expIr(32'(k % 16));
      instR(OP_R);
    end
    expIr(32'd1);
    pushRst(S_F, 1'b1);
    // reset lands in EXEC_R: instruction is abandoned, never retired
    pFetch(OP_R, 1'b0);
    pushS(OP_R, 1'b0, S_D, EN_NONE, D_V, D_M);
    pushRst(S_R, 1'b1);
    expIr(32'd0);
    pushS(OP_R, 1'b0, S_F, EN_NONE, F_V, F_M);
    pushS(OP_R, 1'b0, S_F, EN_NONE, F_V, F_M);
    drain();

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
